// File: rtl/ascon_pack.sv
// Shared Ascon definitions: state type, diffusion rotation constants and the
// per-step rotation tables used by the inverse diffusion layer.
//   type_state         5 rows of 64 bits, row 0 at index 0
//   DIFF_ROT_A/B       rotate-right constants of the forward diffusion layer
//   INV_ROT_A/B        (a << k) mod 64 and (b << k) mod 64, indexed [k][row]
//   type_inv_diff_fsm  control states of the iterative inverse
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    // Squaring steps needed to reach Sigma^63 = Sigma^-1 on a 64-bit word.
    localparam int unsigned NSTEPS = 6;

    localparam int unsigned DIFF_ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned DIFF_ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } type_inv_diff_fsm;

    // Eight entries so any 3-bit step index is in range; entries past the
    // last step are zero, which makes the step an identity (x ^ x ^ x = x).
    typedef logic [7:0][4:0][5:0] type_rot_tab;

    function automatic type_rot_tab build_rot_tab(input logic use_b);
        type_rot_tab tab;
        int unsigned base;
        tab = '0;
        for (int k = 0; k < int'(NSTEPS); k++) begin
            for (int r = 0; r < 5; r++) begin
                base = use_b ? DIFF_ROT_B[r] : DIFF_ROT_A[r];
                tab[k][r] = 6'(base << k);
            end
        end
        return tab;
    endfunction

    localparam type_rot_tab INV_ROT_A = build_rot_tab(1'b0);
    localparam type_rot_tab INV_ROT_B = build_rot_tab(1'b1);

    // Rotate right by n; {x,x} avoids the shift-by-64 corner when n is 0.
    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] dbl;
        dbl = {x, x} >> n;
        return dbl[63:0];
    endfunction

endpackage

// File: rtl/diff_inv_step.sv
// One squaring step of the inverse diffusion layer, purely combinational.
//   state_i  input state (5 x 64)
//   k_i      step index; row i becomes x ^ ror(x, a_i*2^k) ^ ror(x, b_i*2^k)
//   state_o  Sigma_i^(2^k) applied to every row
module diff_inv_step
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [2:0] k_i,
    output type_state  state_o
);

    always_comb begin
        state_o = state_i;
        for (int r = 0; r < 5; r++) begin
            state_o[r] = state_i[r]
                       ^ ror64(state_i[r], INV_ROT_A[k_i][r])
                       ^ ror64(state_i[r], INV_ROT_B[k_i][r]);
        end
    end

endmodule

// File: rtl/couche_diffusion_inv.sv
// Iterative inverse of the Ascon linear diffusion layer.
// Applies Sigma^(2^k) for k = 0..5 to all rows, one step per cycle (two with
// INV_DIFF_UNROLL2_EN defined), behind a single-buffered valid/ready handshake.
//   clock_i  rising-edge clock
//   reset_i  asynchronous active-high reset
//   valid_i  input state valid       ready_o  block idle, can accept
//   state_i  diffused state          state_o  un-diffused state (valid with valid_o)
//   valid_o  result valid, held      ready_i  downstream accepts result
module couche_diffusion_inv
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  type_state state_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state state_o
);

`ifdef INV_DIFF_UNROLL2_EN
    localparam int unsigned STEP_PER_CYC = 2;
`else
    localparam int unsigned STEP_PER_CYC = 1;
`endif

    localparam logic [3:0] NSTEPS_W   = 4'(NSTEPS);
    localparam logic [3:0] STEP_INC_W = 4'(STEP_PER_CYC);

    type_inv_diff_fsm fsm_q;
    type_state        acc_q;
    type_state        acc_step;
    logic [2:0]       step_q;
    logic [2:0]       step_nxt;
    logic [3:0]       step_sum;
    logic             last_step;
    logic             valid_q;
    logic             ready_q;

`ifdef INV_DIFF_UNROLL2_EN
    type_state  acc_mid;
    logic [2:0] step_plus1;

    assign step_plus1 = step_q + 3'd1;

    diff_inv_step u_step0 (
        .state_i (acc_q),
        .k_i     (step_q),
        .state_o (acc_mid)
    );

    diff_inv_step u_step1 (
        .state_i (acc_mid),
        .k_i     (step_plus1),
        .state_o (acc_step)
    );
`else
    diff_inv_step u_step0 (
        .state_i (acc_q),
        .k_i     (step_q),
        .state_o (acc_step)
    );
`endif

    // Saturating step counter; last_step flags the cycle applying step 5.
    always_comb begin
        step_sum  = {1'b0, step_q} + STEP_INC_W;
        last_step = (step_sum >= NSTEPS_W);
        step_nxt  = last_step ? NSTEPS_W[2:0] : step_sum[2:0];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        acc_q   <= state_i;
                        step_q  <= '0;
                        fsm_q   <= RUN;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q  <= acc_step;
                    step_q <= step_nxt;
                    if (last_step) begin
                        fsm_q   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // acc_q is frozen here, so state_o is stable while stalled.
                    if (ready_i) begin
                        fsm_q   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign state_o = acc_q;

endmodule
